conv_frame_ctrl: RTL and testbench

CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_beat_counter.sv | 33 +++
 rtl/conv_frame_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_conv_frame_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution frame controller.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_KLOAD  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } conv_state_e;

  localparam int unsigned DEF_KERNEL_SIZE = 32'd3;
  localparam int unsigned DEF_IMG_LENGTH  = 32'd16;
  localparam int unsigned DEF_IMG_HEIGHT  = 32'd16;
  localparam int unsigned KERNEL_TAPS     = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;
  localparam int unsigned FRAME_PIXELS    = DEF_IMG_LENGTH * DEF_IMG_HEIGHT;
  // Multiplier stage plus filter output register.
  localparam int unsigned DRAIN_CYCLES    = 32'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/conv_beat_counter.sv
// Beat counter with synchronous clear; term flags that the beat in flight is the last one.
module conv_beat_counter #(
  parameter int unsigned TERMINAL = 32'd9,
  parameter int unsigned WIDTH    = $clog2(TERMINAL + 32'd1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic term
);

  localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(TERMINAL - 32'd1);
  localparam logic [WIDTH-1:0] FULL_VAL = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count_r;

  // Count accepted beats, holding at the terminal value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (inc && (count_r != FULL_VAL)) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign term = (count_r == LAST_VAL);

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for a streaming convolution datapath: clear, kernel load, pixel stream, drain.
// Optional macro CONV_FRAME_KREUSE_EN adds input kreuse to skip reloading an already loaded kernel.
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned BITS        = 32'd9,
  parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int unsigned IMG_LENGTH  = DEF_IMG_LENGTH,
  parameter int unsigned IMG_HEIGHT  = DEF_IMG_HEIGHT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
`ifdef CONV_FRAME_KREUSE_EN
  input  logic            kreuse,
`endif
  output logic            busy,
  output logic            done,
  output logic            err,
  input  logic            kin_valid,
  output logic            kin_ready,
  input  logic [BITS-1:0] kin_data,
  input  logic            pin_valid,
  output logic            pin_ready,
  input  logic [BITS-1:0] pin_data,
  output logic            dp_reset,
  output logic            kernel_write_en,
  output logic [BITS-1:0] kernel_out,
  output logic            shift_write_en,
  output logic [BITS-1:0] img_out,
  input  logic            conv_valid,
  input  logic [BITS-1:0] conv_pixel,
  output logic            pix_out_valid,
  output logic [BITS-1:0] pix_out,
  output logic [15:0]     out_count
);

  localparam int unsigned KTAPS   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned NPIX    = IMG_LENGTH * IMG_HEIGHT;
  localparam int unsigned KCNT_W  = $clog2(KTAPS + 32'd1);
  localparam int unsigned PCNT_W  = $clog2(NPIX + 32'd1);
  localparam int unsigned DCNT_W  = $clog2(DRAIN_CYCLES + 32'd1);

  conv_state_e state_r;
  conv_state_e next_state_s;
  logic        kern_term_s;
  logic        pix_term_s;
  logic        drain_term_s;
  logic        reuse_start_s;
  logic        clear_count_s;
  logic        in_run_s;

  assign kin_ready       = (state_r == ST_KLOAD);
  assign kernel_write_en = kin_ready & kin_valid;
  assign kernel_out      = kin_ready ? kin_data : '0;
  assign pin_ready       = (state_r == ST_STREAM);
  assign shift_write_en  = pin_ready & pin_valid;
  assign img_out         = pin_ready ? pin_data : '0;
  assign in_run_s        = (state_r == ST_STREAM) || (state_r == ST_DRAIN);
  assign clear_count_s   = (state_r == ST_CLR) || reuse_start_s;

`ifdef CONV_FRAME_KREUSE_EN
  logic kernel_loaded_r;

  // Remember that a full kernel has been loaded since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      kernel_loaded_r <= 1'b0;
    end else if (kernel_write_en && kern_term_s) begin
      kernel_loaded_r <= 1'b1;
    end else begin
      kernel_loaded_r <= kernel_loaded_r;
    end
  end

  assign reuse_start_s = (state_r == ST_IDLE) & start & kreuse & kernel_loaded_r;
`else
  assign reuse_start_s = 1'b0;
`endif

  conv_beat_counter #(.TERMINAL(KTAPS), .WIDTH(KCNT_W)) u_kern_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (state_r != ST_KLOAD),
    .inc   (kernel_write_en),
    .term  (kern_term_s)
  );

  conv_beat_counter #(.TERMINAL(NPIX), .WIDTH(PCNT_W)) u_pix_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (state_r != ST_STREAM),
    .inc   (shift_write_en),
    .term  (pix_term_s)
  );

  conv_beat_counter #(.TERMINAL(DRAIN_CYCLES), .WIDTH(DCNT_W)) u_drain_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (state_r != ST_DRAIN),
    .inc   (state_r == ST_DRAIN),
    .term  (drain_term_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a pixel gap while streaming is an underrun.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = reuse_start_s ? ST_STREAM : ST_CLR;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CLR:   next_state_s = ST_KLOAD;
      ST_KLOAD: begin
        if (kernel_write_en && kern_term_s) begin
          next_state_s = ST_STREAM;
        end else begin
          next_state_s = ST_KLOAD;
        end
      end
      ST_STREAM: begin
        if (!pin_valid) begin
          next_state_s = ST_ERR;
        end else if (pix_term_s) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (drain_term_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_DONE:  next_state_s = ST_IDLE;
      ST_ERR:   next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Status flags registered from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      dp_reset <= 1'b0;
    end else begin
      busy     <= (next_state_s != ST_IDLE);
      done     <= (next_state_s == ST_DONE) || (next_state_s == ST_ERR);
      dp_reset <= (next_state_s == ST_CLR);
    end
  end

  // Sticky underrun flag, cleared by the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((state_r == ST_STREAM) && !pin_valid) begin
      err <= 1'b1;
    end else if ((state_r == ST_IDLE) && start) begin
      err <= 1'b0;
    end else begin
      err <= err;
    end
  end

  // Result forward register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_out_valid <= 1'b0;
      pix_out       <= '0;
    end else begin
      pix_out_valid <= conv_valid;
      pix_out       <= conv_pixel;
    end
  end

  // Per-frame result counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_count <= 16'd0;
    end else if (clear_count_s) begin
      out_count <= 16'd0;
    end else if (conv_valid && in_run_s) begin
      out_count <= sat_inc16(out_count);
    end else begin
      out_count <= out_count;
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl: randomized frames against a timeline model of the frame sequence.
module tb_conv_frame_ctrl;

  localparam int BITS  = 9;
  localparam int KTAPS = 9;
  localparam int NPIX  = 256;
  localparam int DRAIN = 2;
`ifdef CONV_FRAME_KREUSE_EN
  localparam bit REUSE_BUILD = 1'b1;
`else
  localparam bit REUSE_BUILD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, start;
  logic            kin_valid, pin_valid, conv_valid;
  logic [BITS-1:0] kin_data, pin_data, conv_pixel;
  logic            busy, done, err, kin_ready, pin_ready, dp_reset;
  logic            kernel_write_en, shift_write_en, pix_out_valid;
  logic [BITS-1:0] kernel_out, img_out, pix_out;
  logic [15:0]     out_count;
`ifdef CONV_FRAME_KREUSE_EN
  logic            kreuse;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  bit kernel_loaded_tb = 1'b0;

  always #5 clk = ~clk;

  conv_frame_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef CONV_FRAME_KREUSE_EN
    .kreuse(kreuse),
`endif
    .busy(busy), .done(done), .err(err),
    .kin_valid(kin_valid), .kin_ready(kin_ready), .kin_data(kin_data),
    .pin_valid(pin_valid), .pin_ready(pin_ready), .pin_data(pin_data),
    .dp_reset(dp_reset), .kernel_write_en(kernel_write_en), .kernel_out(kernel_out),
    .shift_write_en(shift_write_en), .img_out(img_out),
    .conv_valid(conv_valid), .conv_pixel(conv_pixel),
    .pix_out_valid(pix_out_valid), .pix_out(pix_out), .out_count(out_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".err"}, err, 0);
    check({tag, ".dp_reset"}, dp_reset, 0);
    check({tag, ".pix_out_valid"}, pix_out_valid, 0);
    check({tag, ".pix_out"}, pix_out, 0);
    check({tag, ".out_count"}, out_count, 0);
    check({tag, ".kin_ready"}, kin_ready, 0);
    check({tag, ".pin_ready"}, pin_ready, 0);
    check({tag, ".kernel_write_en"}, kernel_write_en, 0);
    check({tag, ".shift_write_en"}, shift_write_en, 0);
    check({tag, ".kernel_out"}, kernel_out, 0);
    check({tag, ".img_out"}, img_out, 0);
  endtask

  // One frame. Cycle 0 is the IDLE cycle carrying start. kmode: 0 contiguous, 1 toggling, 2 random.
  // under_at >= 0 withholds the pixel with that index.
  task automatic run_frame(input string name, input int kmode, input int under_at,
                           input bit hold, input bit want_reuse);
    int c, kbeats, stream_first, slen, exp_done, win_end, exp_cv, exp_oc_c2;
    int dp_cnt, dp_first, kwe_cnt, krdy_cnt, swe_cnt, prdy_cnt, first_swe;
    int busy_cnt, done_cnt, done_cyc, data_bad, pix_bad;
    logic err_c1, busy_after;
    logic [15:0] oc_c2;
    logic prev_cv;
    logic [BITS-1:0] prev_cp;
    bit reuse, in_kload, in_stream;

    reuse = want_reuse && kernel_loaded_tb && REUSE_BUILD;
    slen = (under_at >= 0) ? under_at + 1 : NPIX;
    kbeats = 0; stream_first = reuse ? 1 : -1; exp_done = -1; win_end = -1;
    exp_cv = 0; exp_oc_c2 = 0; oc_c2 = 16'hDEAD; err_c1 = 1'bx; busy_after = 1'bx;
    dp_cnt = 0; dp_first = -1; kwe_cnt = 0; krdy_cnt = 0; swe_cnt = 0; prdy_cnt = 0;
    first_swe = -1; busy_cnt = 0; done_cnt = 0; done_cyc = -1; data_bad = 0; pix_bad = 0;
    prev_cv = conv_valid; prev_cp = conv_pixel;

    for (c = 0; c < 2000; c++) begin
      start = (c == 0) || (hold && (exp_done < 0 || c <= exp_done));
`ifdef CONV_FRAME_KREUSE_EN
      kreuse = want_reuse;
`endif
      in_kload  = !reuse && (c >= 2) && (kbeats < KTAPS);
      in_stream = (stream_first >= 0) && (c >= stream_first) && (c < stream_first + slen);
      if (kmode == 1)             kin_valid = (c % 2 == 0);
      else if (kmode == 0 && in_kload) kin_valid = 1'b1;
      else                        kin_valid = 1'($urandom_range(0, 1));
      if (in_stream) pin_valid = !((under_at >= 0) && (c == stream_first + under_at));
      else           pin_valid = 1'($urandom_range(0, 1));
      kin_data   = BITS'($urandom);
      pin_data   = BITS'($urandom);
      conv_valid = 1'($urandom_range(0, 1));
      conv_pixel = BITS'($urandom);
      if (in_kload && kin_valid) begin
        kbeats++;
        if (kbeats == KTAPS) stream_first = c + 1;
      end
      if (stream_first >= 0 && exp_done < 0) begin
        exp_done = (under_at >= 0) ? stream_first + under_at + 1 : stream_first + NPIX + DRAIN;
        win_end  = (under_at >= 0) ? stream_first + under_at : stream_first + NPIX + DRAIN - 1;
      end

      @(negedge clk);
      busy_cnt += busy;
      if (dp_reset) begin dp_cnt++; if (dp_first < 0) dp_first = c; end
      kwe_cnt  += kernel_write_en;
      krdy_cnt += kin_ready;
      swe_cnt  += shift_write_en;
      prdy_cnt += pin_ready;
      if (shift_write_en && first_swe < 0) first_swe = c;
      if (kernel_write_en && kernel_out !== kin_data) data_bad++;
      if (shift_write_en && img_out !== pin_data) data_bad++;
      if (done) begin done_cnt++; done_cyc = c; end
      if (pix_out_valid !== prev_cv || pix_out !== prev_cp) pix_bad++;
      if (c == 1) err_c1 = err;
      if (c == 2) begin oc_c2 = out_count; exp_oc_c2 = exp_cv; end
      if (exp_done >= 0 && c == exp_done + 1) busy_after = busy;
      if (stream_first >= 0 && c >= stream_first && c <= win_end && conv_valid) exp_cv++;
      prev_cv = conv_valid;
      prev_cp = conv_pixel;
      tick();
      if (exp_done >= 0 && c == exp_done + 1) break;
    end

    if (!reuse && kbeats == KTAPS) kernel_loaded_tb = 1'b1;
    start = 1'b0;

    check({name, ".err_cleared_on_start"}, err_c1, 0);
    check({name, ".dp_reset_pulses"}, dp_cnt, reuse ? 0 : 1);
    check({name, ".dp_reset_cycle"}, dp_first, reuse ? -1 : 1);
    check({name, ".kernel_write_en_pulses"}, kwe_cnt, reuse ? 0 : KTAPS);
    check({name, ".kin_ready_cycles"}, krdy_cnt, reuse ? 0 : stream_first - 2);
    check({name, ".stream_entry_cycle"}, first_swe, stream_first);
    check({name, ".shift_write_en_pulses"}, swe_cnt, (under_at >= 0) ? under_at : NPIX);
    check({name, ".pin_ready_cycles"}, prdy_cnt, slen);
    check({name, ".busy_cycles"}, busy_cnt, exp_done);
    check({name, ".done_pulses"}, done_cnt, 1);
    check({name, ".done_cycle"}, done_cyc, exp_done);
    check({name, ".idle_after_done"}, busy_after, 0);
    check({name, ".err_final"}, err, (under_at >= 0) ? 1 : 0);
    check({name, ".out_count_restart"}, oc_c2, exp_oc_c2);
    check({name, ".out_count_final"}, out_count, exp_cv);
    check({name, ".datapath_data"}, data_bad, 0);
    check({name, ".pix_out_delay"}, pix_bad, 0);
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0;
    kin_valid = 1'b0; pin_valid = 1'b0; conv_valid = 1'b0;
    kin_data = '0; pin_data = '0; conv_pixel = '0;
`ifdef CONV_FRAME_KREUSE_EN
    kreuse = 1'b0;
`endif
    repeat (3) tick();
    @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    tick();

    run_frame("first_kreuse_no_kernel", 0, -1, 1'b0, 1'b1);
    run_frame("toggle_kernel_hold_start", 1, -1, 1'b1, 1'b0);
    run_frame("underrun_at_100", 2, 100, 1'b0, 1'b0);
    run_frame("kernel_reuse", 0, -1, 1'b0, 1'b1);
    run_frame("random_gaps", 2, -1, 1'b0, 1'b0);

    // Abort during kernel load after four beats.
    start = 1'b1; kin_valid = 1'b0; conv_valid = 1'b0;
`ifdef CONV_FRAME_KREUSE_EN
    kreuse = 1'b0;
`endif
    tick();
    start = 1'b0;
    tick();
    kin_valid = 1'b1;
    repeat (4) tick();
    reset = 1'b1; kin_data = 9'h1AB; pin_valid = 1'b1; pin_data = 9'h0F3;
    conv_valid = 1'b1; conv_pixel = 9'h155;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_quiet("abort");
    tick();
    kernel_loaded_tb = 1'b0;
    kin_valid = 1'b0; pin_valid = 1'b0; conv_valid = 1'b0; conv_pixel = '0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dones += done;
      tick();
    end
    check("abort.no_done", dones, 0);
    check("abort.still_idle", busy, 0);

    run_frame("post_abort_kreuse", 0, -1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
